// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: datapath width, the
// canonical NOP encoding and the buffer entry layout that pairs a fetched word
// with the PC it came from.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// DEPTH-entry FIFO of fetch_entry_t sitting between instruction memory and
// decode. The head entry is read straight out of the storage registers, so
// nothing downstream sees a combinational path from the memory read data.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset, clears storage and pointers
//   i_push       in   write i_push_entry at the tail
//   i_push_entry in   entry to write
//   i_pop        in   retire the head entry
//   i_flush      in   empty the buffer (wins over push; pop is harmless)
//   o_count      out  number of valid entries, 0..DEPTH
//   o_head       out  head entry
//   o_head_valid out  buffer not empty
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  fetch_entry_t                 i_push_entry,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output fetch_entry_t                 o_head,
    output logic                         o_head_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [PW-1:0]   w_wr_ptr_inc;
    logic [PW-1:0]   w_rd_ptr_inc;

    // Explicit wrap so non-power-of-two depths work.
    assign w_wr_ptr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_entry;
                r_wr_ptr        <= w_wr_ptr_inc;
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_count      = r_count;
    assign o_head       = r_mem[r_rd_ptr];
    assign o_head_valid = (r_count != '0);

`ifndef SYNTHESIS
    // The credit logic upstream must never let a push land on a full buffer
    // unless the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(i_push && !i_pop && !i_flush && (r_count == CW'(DEPTH))));
`endif

endmodule : fetch_buffer

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage downstream of the PC register. Presents the PC to a
// synchronous instruction memory, tracks the one outstanding request, pairs
// the returned word with its PC into a small buffer toward decode, throttles
// the PC through pc_stall and squashes wrong-path words on redirect.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   pc_in          in   current PC
//   pc_ena         in   fetch enable
//   redirect       in   branch/jump taken this cycle
//   imem_addr      out  memory address (= pc_in)
//   imem_en        out  memory read enable
//   imem_rdata     in   read data, one cycle after imem_en
//   pc_stall       out  hold the PC register
//   if_valid       out  head valid toward decode
//   id_ready       in   decode takes the head this cycle
//   if_pc          out  head PC
//   if_instr       out  head instruction word
//   if_misaligned  out  head PC was not word aligned
//
// Handshake: a word moves to decode in every cycle where if_valid and id_ready
// are both high; if_valid never depends on id_ready, and the head is stable
// while if_valid is high and id_ready is low.
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             pc_ena,
    input  logic             redirect,
    output logic [XLEN-1:0]  imem_addr,
    output logic             imem_en,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             pc_stall,
    output logic             if_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  if_pc,
    output logic [XLEN-1:0]  if_instr,
    output logic             if_misaligned
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_req_pc;
    logic            r_req_valid;

    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;
    logic            w_head_valid;
    logic            w_pop;
    logic            w_push;
    logic [CW:0]     w_credit;
    fetch_entry_t    w_push_entry;

    assign w_pop = w_head_valid & id_ready;

    // Slots already promised: buffered words plus the word returning this
    // cycle, less the one decode takes now. One extra bit keeps the sum exact.
    assign w_credit = {1'b0, w_count} + (CW+1)'(r_req_valid) - (CW+1)'(w_pop);

    // On redirect the PC must load the vector, so stall is released even if
    // the buffer is full; the flush below makes room.
    assign pc_stall  = ~redirect & (w_credit >= (CW+1)'(DEPTH));
    assign imem_en   = pc_ena & ~pc_stall;
    assign imem_addr = pc_in;

    // Request tracking: a request issued in a redirect cycle is for the old
    // sequential path and is killed here so its data is never pushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_valid <= 1'b0;
            r_req_pc    <= '0;
        end else begin
            r_req_valid <= imem_en & ~redirect;
            if (imem_en) begin
                r_req_pc <= pc_in;
            end
        end
    end

    // The response arriving in a redirect cycle is on the wrong path.
    assign w_push = r_req_valid & ~redirect;

    assign w_push_entry.pc         = r_req_pc;
    assign w_push_entry.instr      = imem_rdata;
    assign w_push_entry.misaligned = (r_req_pc[1:0] != 2'b00);

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush      (redirect),
        .o_count      (w_count),
        .o_head       (w_head),
        .o_head_valid (w_head_valid)
    );

    assign if_valid      = w_head_valid;
    assign if_pc         = w_head.pc;
    assign if_instr      = w_head.instr;
    assign if_misaligned = w_head.misaligned;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_ena;
    logic        redirect;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        pc_stall;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;

    logic [31:0] vect;
    int          checks;
    int          failures;

    fetch_stage #(.DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .pc_ena        (pc_ena),
        .redirect      (redirect),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .imem_rdata    (imem_rdata),
        .pc_stall      (pc_stall),
        .if_valid      (if_valid),
        .id_ready      (id_ready),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_misaligned (if_misaligned)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic mis);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_instr"}, if_instr, instr);
        chk({tag, "_mis"}, {31'b0, if_misaligned}, {31'b0, mis});
    endtask

    // Advance one clock, acting as PC register and synchronous memory
    // (returns 0x100 + address). New values are applied 1 time unit after the edge.
    task automatic step();
        logic [31:0] nxt_pc;
        logic [31:0] nxt_rd;
        nxt_pc = redirect ? vect : (pc_stall ? pc_in : pc_in + 32'd4);
        nxt_rd = imem_en ? (32'h100 + imem_addr) : imem_rdata;
        @(posedge clk);
        #1;
        pc_in      = nxt_pc;
        imem_rdata = nxt_rd;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        pc_in      = 32'h0;
        pc_ena     = 1'b1;
        redirect   = 1'b0;
        id_ready   = 1'b1;
        imem_rdata = 32'h0;
        vect       = 32'h40;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_mis", {31'b0, if_misaligned}, 32'd0);

        // 1. streaming, cycle 0 = first cycle out of reset
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("c0_en", {31'b0, imem_en}, 32'd1);
        chk("c0_stall", {31'b0, pc_stall}, 32'd0);
        chk("c0_valid", {31'b0, if_valid}, 32'd0);
        step(); #1;
        chk("c1_valid", {31'b0, if_valid}, 32'd0);
        step(); #1;
        chk_head("c2", 32'h0, 32'h100, 1'b0);
        step(); #1;
        chk_head("c3", 32'h4, 32'h104, 1'b0);
        step();
        // 2. decode stalls while (8,0x108) is head
        id_ready = 1'b0;
        #1;
        chk_head("c4", 32'h8, 32'h108, 1'b0);
        chk("c4_stall", {31'b0, pc_stall}, 32'd1);
        chk("c4_en", {31'b0, imem_en}, 32'd0);
        step(); #1;
        chk("c5_stall", {31'b0, pc_stall}, 32'd1);
        chk("c5_en", {31'b0, imem_en}, 32'd0);
        chk("c5_head_pc", if_pc, 32'h8);
        step();
        id_ready = 1'b1;
        #1;
        chk("c6_head_pc", if_pc, 32'h8);
        chk("c6_stall", {31'b0, pc_stall}, 32'd0);
        chk("c6_addr", imem_addr, 32'h10);
        step(); #1;
        chk_head("c7", 32'hC, 32'h10C, 1'b0);
        step();
        // 3. redirect to 0x40 with 0x14 in flight and 0x18 issuing
        redirect = 1'b1;
        #1;
        chk_head("c8", 32'h10, 32'h110, 1'b0);
        chk("c8_stall", {31'b0, pc_stall}, 32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("c9_valid", {31'b0, if_valid}, 32'd0);
        chk("c9_addr", imem_addr, 32'h40);
        chk("c9_en", {31'b0, imem_en}, 32'd1);
        step(); #1;
        chk("c10_valid", {31'b0, if_valid}, 32'd0);
        step();
        // 4. fill the buffer, then redirect while full
        id_ready = 1'b0;
        #1;
        chk_head("c11", 32'h40, 32'h140, 1'b0);
        chk("c11_stall", {31'b0, pc_stall}, 32'd1);
        step();
        redirect = 1'b1;
        #1;
        chk("c12_head_pc", if_pc, 32'h40);
        chk("c12_stall", {31'b0, pc_stall}, 32'd0);
        chk("c12_en", {31'b0, imem_en}, 32'd1);
        step();
        redirect = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("c13_valid", {31'b0, if_valid}, 32'd0);
        chk("c13_addr", imem_addr, 32'h40);
        step(); #1;
        chk("c14_valid", {31'b0, if_valid}, 32'd0);
        step();
        // 5. redirect (coinciding with a pop) to misaligned 0x2
        vect     = 32'h2;
        redirect = 1'b1;
        #1;
        chk_head("c15", 32'h40, 32'h140, 1'b0);
        step();
        redirect = 1'b0;
        #1;
        chk("c16_valid", {31'b0, if_valid}, 32'd0);
        step(); #1;
        step();
        vect     = 32'h20;
        redirect = 1'b1;
        #1;
        chk_head("c18", 32'h2, 32'h102, 1'b1);
        step();
        redirect = 1'b0;
        #1;
        chk("c19_valid", {31'b0, if_valid}, 32'd0);
        step(); #1;
        step();
        id_ready = 1'b0;
        #1;
        chk_head("c21", 32'h20, 32'h120, 1'b0);
        // 6. full buffer, then asynchronous reset mid-cycle
        step(); #1;
        chk("c22_stall", {31'b0, pc_stall}, 32'd1);
        chk("c22_head_pc", if_pc, 32'h20);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'b0, if_valid}, 32'd0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_instr", if_instr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b1;
        pc_in      = 32'h0;
        imem_rdata = 32'h0;
        id_ready   = 1'b1;
        #1;
        chk("r0_valid", {31'b0, if_valid}, 32'd0);
        chk("r0_stall", {31'b0, pc_stall}, 32'd0);
        chk("r0_addr", imem_addr, 32'h0);
        step(); #1;
        chk("r1_valid", {31'b0, if_valid}, 32'd0);
        step(); #1;
        chk_head("r2", 32'h0, 32'h100, 1'b0);
        step(); #1;
        chk_head("r3", 32'h4, 32'h104, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage
